// File: rtl/uart_pkg.sv
// Shared constants, state encoding and frame-length helper for the UART transmit queue.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 32'd104;
  localparam int DEF_FRAME_BITS   = 32'd10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } txq_state_e;

  function automatic int frame_clks(input int clks_per_bit, input int frame_bits,
                                    input int guard_clks);
    return frame_bits * clks_per_bit + guard_clks;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous circular byte FIFO; full/empty are derived from the occupancy count.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 wr_data,
  input  logic                       pop,
  output logic [7:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          push_s;

  // Accept decision uses the registered full flag, so a same-edge pop never frees room.
  always_comb begin
    push_s      = push && !full_r;
    count_nxt_s = count_r;
    if (push_s && !pop) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!push_s && pop) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)    rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == CW'(0));
    end
  end

  // Storage array; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data    = mem_r[rd_ptr_r];
  assign count      = count_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign empty_next = (count_nxt_s == CW'(0));

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus pacing sequencer feeding uart_tx with spaced one-clock tx_enable pulses.
// Optional sticky overflow flag enabled by defining UART_TXQ_OVERFLOW_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int GUARD_CLKS   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       tx_enable,
  output logic [7:0]                 tx_byte,
  output logic                       idle,
  output logic                       overflow
);

  localparam int            FRAME_CLKS = frame_clks(CLKS_PER_BIT, FRAME_BITS, GUARD_CLKS);
  localparam int            TW         = $clog2(FRAME_CLKS);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CLKS - 1);

  txq_state_e    state_r, state_nxt_s;
  logic [TW-1:0] timer_r, timer_nxt_s;
  logic          tx_en_r, tx_en_nxt_s;
  logic [7:0]    tx_byte_r, tx_byte_nxt_s;
  logic          idle_r, idle_nxt_s;
  logic          pop_s;
  logic [7:0]    fifo_rd_data_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          fifo_empty_nxt_s;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wr_en),
    .wr_data    (wr_data),
    .pop        (pop_s),
    .rd_data    (fifo_rd_data_s),
    .count      (count),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .empty_next (fifo_empty_nxt_s)
  );

  // Pacing FSM: launch a byte from IDLE, then hold off for a whole frame plus guard.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    tx_en_nxt_s   = 1'b0;
    tx_byte_nxt_s = tx_byte_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s         = 1'b1;
          tx_en_nxt_s   = 1'b1;
          tx_byte_nxt_s = fifo_rd_data_s;
          timer_nxt_s   = TIMER_LOAD;
          state_nxt_s   = WAIT;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      WAIT: begin
        if (timer_r == TW'(0)) begin
          state_nxt_s = IDLE;
        end else begin
          timer_nxt_s = timer_r - TW'(1);
        end
      end
      default: begin
        state_nxt_s = WAIT;
        timer_nxt_s = TIMER_LOAD;
      end
    endcase
    idle_nxt_s = (state_nxt_s == IDLE) && fifo_empty_nxt_s;
  end

  // Reset parks the FSM in WAIT so a frame already inside uart_tx can finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= WAIT;
      timer_r   <= TIMER_LOAD;
      tx_en_r   <= 1'b0;
      tx_byte_r <= 8'h00;
      idle_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      tx_en_r   <= tx_en_nxt_s;
      tx_byte_r <= tx_byte_nxt_s;
      idle_r    <= idle_nxt_s;
    end
  end

`ifdef UART_TXQ_OVERFLOW_EN
  logic overflow_r;

  // Sticky record of any write refused because the queue was full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (wr_en && fifo_full_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

  assign full      = fifo_full_s;
  assign empty     = fifo_empty_s;
  assign tx_enable = tx_en_r;
  assign tx_byte   = tx_byte_r;
  assign idle      = idle_r;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected bytes, a monitor checks each pulse.
module tb_uart_tx_queue;

  localparam int DEPTH   = 16;
  localparam int SPACING = 1043;
`ifdef UART_TXQ_OVERFLOW_EN
  localparam logic OV_EXP = 1'b1;
`else
  localparam logic OV_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, tx_enable, idle, overflow;
  logic [4:0] count;
  logic [7:0] tx_byte;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         pulse_count = 0;
  int         last_pulse = -1;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] exp_q[$];
  int         pulse_cyc[$];

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .tx_enable (tx_enable),
    .tx_byte   (tx_byte),
    .idle      (idle),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    chk("drain_complete", exp_q.size(), 0);
  endtask

  // Monitor: every pulse must match the next expected byte and respect the frame spacing.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      last_byte  = 8'h00;
      last_pulse = -1;
    end else if (tx_enable) begin
      pulse_count++;
      pulse_cyc.push_back(cyc);
      if (last_pulse >= 0) chk("pulse_spacing_min", (cyc - last_pulse) >= SPACING, 1);
      chk("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("tx_byte_order", tx_byte, exp_q.pop_front());
      last_byte  = tx_byte;
      last_pulse = cyc;
    end else begin
      chk("tx_byte_hold", tx_byte, last_byte);
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int guard;
    int acc;
    int pbase;
    int n;
    int seen;
    logic [7:0] r;

    // Reset state
    tick(3);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_idle", idle, 0);
    rst_n = 1'b1;

    // Test 1: single byte latency and return to idle
    tick(SPACING);
    chk("t1_idle_before", idle, 1);
    write_byte(8'h41, 1'b1);
    chk("t1_no_pulse_yet", tx_enable, 0);
    chk("t1_count_one", count, 1);
    tick(1);
    chk("t1_pulse", tx_enable, 1);
    chk("t1_byte", tx_byte, 8'h41);
    chk("t1_count_zero", count, 0);
    tick(1);
    chk("t1_pulse_one_clk", tx_enable, 0);
    tick(1040);
    chk("t1_still_wait", idle, 0);
    tick(1);
    chk("t1_idle_after", idle, 1);

    // Test 2: four back-to-back bytes, exact spacing
    pulse_cyc.delete();
    for (int i = 0; i < 4; i++) write_byte(8'h30 + 8'(i), 1'b1);
    chk("t2_count_peak", count, 3);
    base = cyc;
    tick(4 * SPACING);
    chk("t2_pulse_count", pulse_cyc.size(), 4);
    if (pulse_cyc.size() == 4) begin
      chk("t2_first_pulse", pulse_cyc[0], base - 2);
      for (int i = 1; i < 4; i++) chk("t2_spacing", pulse_cyc[i] - pulse_cyc[i-1], SPACING);
    end
    chk("t2_idle", idle, 1);

    // Test 3: fill during WAIT, 17th write dropped
    write_byte(8'hA0, 1'b1);
    tick(3);
    for (int i = 0; i < 15; i++) write_byte(8'hB0 + 8'(i), 1'b1);
    chk("t3_not_full_15", full, 0);
    write_byte(8'hBF, 1'b1);
    chk("t3_full_16", full, 1);
    chk("t3_count_16", count, 16);
    write_byte(8'hC0, 1'b0);
    chk("t3_count_after_drop", count, 16);
    chk("t3_full_after_drop", full, 1);
    chk("t3_overflow", overflow, OV_EXP);

    // Test 4: write while full on the pop edge is dropped
    guard   = 0;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    while (full && guard < 1100) begin
      @(negedge clk);
      guard++;
    end
    wr_en = 1'b0;
    chk("t4_pop_seen", guard < 1100, 1);
    chk("t4_count_15", count, 15);
    chk("t4_not_full", full, 0);
    wait_drain(20000);
    tick(SPACING + 2);
    chk("t4_idle", idle, 1);
    chk("t4_empty", empty, 1);

    // Test 5: reset mid-WAIT discards queued bytes
    write_byte(8'hD0, 1'b1);
    tick(3);
    for (int i = 1; i < 4; i++) write_byte(8'hD0 + 8'(i), 1'b1);
    chk("t5_count_3", count, 3);
    tick(500);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t5_count_0", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_full", full, 0);
    chk("t5_overflow_cleared", overflow, 0);
    chk("t5_tx_byte", tx_byte, 8'h00);
    seen = 0;
    for (int i = 0; i < SPACING; i++) begin
      tick(1);
      if (tx_enable) seen++;
    end
    chk("t5_no_pulses", seen, 0);
    chk("t5_idle", idle, 1);

    // Test 6: 40 random bytes across pointer wrap, writes gated by modelled occupancy
    pbase = pulse_count;
    acc   = 0;
    n     = 0;
    while (acc < 40 && n < 60000) begin
      if (acc - (pulse_count - pbase) < DEPTH) begin
        r       = 8'($urandom_range(0, 255));
        wr_en   = 1'b1;
        wr_data = r;
        exp_q.push_back(r);
        acc++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0;
    chk("t6_all_written", acc, 40);
    wait_drain(20000);
    chk("t6_pulse_total", pulse_count - pbase, 40);
    chk("t6_empty", empty, 1);
    chk("t6_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
